// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cpu_pkg                                               |
// | Purpose  : Shared RV32I encodings, ALU operation enum and width  |
// |            defaults for the cpu_core hierarchy.                  |
// | Ports    : none (package)                                        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int PC_W_DEF = 8;

  // Major opcodes handled by the core; anything else retires as a NOP.
  localparam logic [6:0] C_OPC_OP     = 7'h33;
  localparam logic [6:0] C_OPC_OP_IMM = 7'h13;
  localparam logic [6:0] C_OPC_LUI    = 7'h37;
  localparam logic [6:0] C_OPC_AUIPC  = 7'h17;
  localparam logic [6:0] C_OPC_JAL    = 7'h6F;
  localparam logic [6:0] C_OPC_JALR   = 7'h67;
  localparam logic [6:0] C_OPC_BRANCH = 7'h63;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] C_F3_ADD  = 3'b000;
  localparam logic [2:0] C_F3_SLL  = 3'b001;
  localparam logic [2:0] C_F3_SLT  = 3'b010;
  localparam logic [2:0] C_F3_SLTU = 3'b011;
  localparam logic [2:0] C_F3_XOR  = 3'b100;
  localparam logic [2:0] C_F3_SR   = 3'b101;
  localparam logic [2:0] C_F3_OR   = 3'b110;
  localparam logic [2:0] C_F3_AND  = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] C_F3_BEQ  = 3'b000;
  localparam logic [2:0] C_F3_BNE  = 3'b001;
  localparam logic [2:0] C_F3_BLT  = 3'b100;
  localparam logic [2:0] C_F3_BGE  = 3'b101;
  localparam logic [2:0] C_F3_BLTU = 3'b110;
  localparam logic [2:0] C_F3_BGEU = 3'b111;

  // funct7: base encoding and the SUB/SRA alternate
  localparam logic [6:0] C_F7_BASE = 7'h00;
  localparam logic [6:0] C_F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/cpu_core_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu                                                   |
// | Purpose  : Combinational RV32I integer ALU, 32-bit wrap-around.  |
// | Ports    : a_i, b_i   operands                                   |
// |            op_i       operation select (alu_op_t)                |
// |            result_o   result                                     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module alu
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_t         op_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] w_shamt;
  assign w_shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << w_shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> w_shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> w_shamt);
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cpu_core                                              |
// | Purpose  : Single-cycle RV32I integer core (no data memory).     |
// |            Decode, immediates, register file and PC live here;   |
// |            arithmetic is delegated to the alu sub-module.        |
// | Ports    : clk      clock, rising edge                           |
// |            rst      synchronous active-high reset                |
// |            ins_in   instruction at word index pc (comb. fetch)   |
// |            cpu_set  run enable (0 = hold all state)              |
// |            pc       current instruction word index               |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module cpu_core
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ins_in,
  input  logic            cpu_set,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0] regs [32];

  // Instruction fields
  logic [6:0] w_opcode, w_f7;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_f3;
  assign w_opcode = ins_in[6:0];
  assign w_rd     = ins_in[11:7];
  assign w_f3     = ins_in[14:12];
  assign w_rs1    = ins_in[19:15];
  assign w_rs2    = ins_in[24:20];
  assign w_f7     = ins_in[31:25];

  // x0 is forced to zero on the read side as well as dropped on write
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : regs[w_rs2];

  // Immediates
  logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_j, w_imm_u;
  assign w_imm_i = {{20{ins_in[31]}}, ins_in[31:20]};
  assign w_imm_b = {{20{ins_in[31]}}, ins_in[7], ins_in[30:25], ins_in[11:8], 1'b0};
  assign w_imm_j = {{12{ins_in[31]}}, ins_in[19:12], ins_in[20], ins_in[30:21], 1'b0};
  assign w_imm_u = {ins_in[31:12], 12'b0};

  // Byte address of the current instruction and the return address
  logic [XLEN-1:0] w_pc_byte, w_link, w_jalr_t;
  assign w_pc_byte = {{(XLEN-PC_W-2){1'b0}}, pc_q, 2'b00};
  assign w_link    = w_pc_byte + XLEN'(4);
  assign w_jalr_t  = (w_rs1_val + w_imm_i) & ~XLEN'(1);

  // PC is a word index, so offsets and jump targets drop their two low
  // bits and everything above the PC width wraps away.
  logic w_unused;
  assign w_unused = ^{w_imm_b[XLEN-1:PC_W+2], w_imm_b[1:0],
                      w_imm_j[XLEN-1:PC_W+2], w_imm_j[1:0],
                      w_jalr_t[XLEN-1:PC_W+2], w_jalr_t[1:0]};

  alu_op_t         w_alu_op;
  logic [XLEN-1:0] w_alu_b, w_alu_res, w_wdata;
  logic            w_we, w_take;

  alu #(.XLEN(XLEN)) u_alu (
    .a_i      (w_rs1_val),
    .b_i      (w_alu_b),
    .op_i     (w_alu_op),
    .result_o (w_alu_res)
  );

  always_comb begin
    pc_d     = pc_q + PC_W'(1);
    w_we     = 1'b0;
    w_alu_op = ALU_ADD;
    w_alu_b  = w_rs2_val;
    w_wdata  = w_alu_res;
    w_take   = 1'b0;
    case (w_opcode)
      C_OPC_OP: begin
        if (w_f7 == C_F7_BASE) begin
          w_we = 1'b1;
          case (w_f3)
            C_F3_ADD:  w_alu_op = ALU_ADD;
            C_F3_SLL:  w_alu_op = ALU_SLL;
            C_F3_SLT:  w_alu_op = ALU_SLT;
            C_F3_SLTU: w_alu_op = ALU_SLTU;
            C_F3_XOR:  w_alu_op = ALU_XOR;
            C_F3_SR:   w_alu_op = ALU_SRL;
            C_F3_OR:   w_alu_op = ALU_OR;
            default:   w_alu_op = ALU_AND;
          endcase
        end else if (w_f7 == C_F7_ALT && w_f3 == C_F3_ADD) begin
          w_we     = 1'b1;
          w_alu_op = ALU_SUB;
        end else if (w_f7 == C_F7_ALT && w_f3 == C_F3_SR) begin
          w_we     = 1'b1;
          w_alu_op = ALU_SRA;
        end
      end
      C_OPC_OP_IMM: begin
        w_alu_b = w_imm_i;
        w_we    = 1'b1;
        case (w_f3)
          C_F3_ADD:  w_alu_op = ALU_ADD;
          C_F3_SLT:  w_alu_op = ALU_SLT;
          C_F3_SLTU: w_alu_op = ALU_SLTU;
          C_F3_XOR:  w_alu_op = ALU_XOR;
          C_F3_OR:   w_alu_op = ALU_OR;
          C_F3_AND:  w_alu_op = ALU_AND;
          C_F3_SLL: begin
            w_alu_op = ALU_SLL;
            w_we     = (w_f7 == C_F7_BASE);
          end
          default: begin  // shift right: funct7 selects logical/arithmetic
            w_alu_op = (w_f7 == C_F7_ALT) ? ALU_SRA : ALU_SRL;
            w_we     = (w_f7 == C_F7_BASE) || (w_f7 == C_F7_ALT);
          end
        endcase
      end
      C_OPC_LUI: begin
        w_we    = 1'b1;
        w_wdata = w_imm_u;
      end
      C_OPC_AUIPC: begin
        w_we    = 1'b1;
        w_wdata = w_pc_byte + w_imm_u;
      end
      C_OPC_JAL: begin
        w_we    = 1'b1;
        w_wdata = w_link;
        pc_d    = pc_q + w_imm_j[PC_W+1:2];
      end
      C_OPC_JALR: begin
        if (w_f3 == 3'b000) begin
          w_we    = 1'b1;
          w_wdata = w_link;
          pc_d    = w_jalr_t[PC_W+1:2];
        end
      end
      C_OPC_BRANCH: begin
        case (w_f3)
          C_F3_BEQ:  w_take = (w_rs1_val == w_rs2_val);
          C_F3_BNE:  w_take = (w_rs1_val != w_rs2_val);
          C_F3_BLT:  w_take = ($signed(w_rs1_val) <  $signed(w_rs2_val));
          C_F3_BGE:  w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
          C_F3_BLTU: w_take = (w_rs1_val <  w_rs2_val);
          C_F3_BGEU: w_take = (w_rs1_val >= w_rs2_val);
          default:   w_take = 1'b0;
        endcase
        if (w_take) pc_d = pc_q + w_imm_b[PC_W+1:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (cpu_set) begin
      pc_q <= pc_d;
      if (w_we && (w_rd != 5'd0)) regs[w_rd] <= w_wdata;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_cpu_core                                           |
// | Purpose  : Self-checking bench for cpu_core: directed programs   |
// |            followed by random instruction streams, compared      |
// |            against an instruction-level reference model.         |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_cpu_core;

  logic        clk;
  logic        rst;
  logic [31:0] ins_in;
  logic        cpu_set;
  logic [7:0]  pc;

  cpu_core #(.XLEN(32), .PC_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ins_in  (ins_in),
    .cpu_set (cpu_set),
    .pc      (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference architectural state
  logic [31:0] m_regs [32];
  int          m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] arith(input int f3, input bit alt,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      0: r = alt ? a - b : a + b;
      1: r = a << sh;
      2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: r = (a < b) ? 32'd1 : 32'd0;
      4: r = a ^ b;
      5: begin
        if (alt) r = $signed(a) >>> sh;
        else     r = a >> sh;
      end
      6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic model_exec(input logic [31:0] ins);
    int op, f3, f7, rd, immi, immb, immj, npc;
    logic [31:0] a, b, res, t, upper;
    bit we, take;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    rd = int'(ins[11:7]);
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    immi = $signed(ins[31:20]);
    immb = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    immj = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
    upper = {ins[31:12], 12'b0};
    npc = (m_pc + 1) % 256;
    we = 0; res = '0;
    case (op)
      'h33: if (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))) begin
        we = 1; res = arith(f3, f7 == 'h20, a, b);
      end
      'h13: begin
        if (f3 == 1)      we = (f7 == 0);
        else if (f3 == 5) we = (f7 == 0 || f7 == 'h20);
        else              we = 1;
        res = arith(f3, (f3 == 5 && f7 == 'h20), a, 32'(immi));
      end
      'h37: begin we = 1; res = upper; end
      'h17: begin we = 1; res = 32'(m_pc * 4) + upper; end
      'h6F: begin
        we = 1; res = 32'(m_pc * 4 + 4);
        npc = ((m_pc * 4 + immj) >>> 2) & 255;
      end
      'h67: if (f3 == 0) begin
        t = (a + 32'(immi)) & ~32'd1;
        we = 1; res = 32'(m_pc * 4 + 4);
        npc = int'(t >> 2) & 255;
      end
      'h63: begin
        case (f3)
          0: take = (a == b);
          1: take = (a != b);
          4: take = ($signed(a) <  $signed(b));
          5: take = ($signed(a) >= $signed(b));
          6: take = (a <  b);
          7: take = (a >= b);
          default: take = 0;
        endcase
        if (take) npc = ((m_pc * 4 + immb) >>> 2) & 255;
      end
      default: ;
    endcase
    if (we && rd != 0) m_regs[rd] = res;
    m_pc = npc;
  endtask

  // One clock: drive, advance the model, compare the whole architectural state.
  task automatic step(input bit r, input bit en, input logic [31:0] ins);
    rst = r; cpu_set = en; ins_in = ins;
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else if (en) begin
      model_exec(ins);
    end
    check("pc", {24'b0, pc}, 32'(m_pc));
    for (int i = 0; i < 32; i++) check($sformatf("x%0d", i), dut.regs[i], m_regs[i]);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step(1, 0, $urandom);
  endtask

  function automatic logic [31:0] rand_ins();
    int k, rd, rs1, rs2, f3, imm;
    k = $urandom_range(0, 9);
    rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7);
    f3 = $urandom_range(0, 7); imm = int'($urandom);
    case (k)
      0: return enc_r(($urandom_range(0, 3) == 0) ? 'h20 : (($urandom_range(0, 7) == 0) ? imm : 0),
                      rs2, rs1, f3, rd);
      1, 2: begin
        if (f3 == 1 || f3 == 5)
          imm = {($urandom_range(0, 2) == 0) ? 7'h20 : (($urandom_range(0, 4) == 0) ? imm[11:5] : 7'h00),
                 imm[4:0]};
        return enc_i(imm, rs1, f3, rd, 'h13);
      end
      3: return enc_u(imm, rd, 'h37);
      4: return enc_u(imm, rd, 'h17);
      5: return enc_j(imm, rd);
      6: return enc_i(imm, rs1, ($urandom_range(0, 4) == 0) ? f3 : 0, rd, 'h67);
      7, 8: return enc_b(imm, rs2, rs1, f3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; cpu_set = 1'b0; ins_in = '0;
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;

    // Reset and hold
    for (int i = 0; i < 10; i++) step(1, 1, $urandom);
    check("reset_pc", {24'b0, pc}, 32'd0);
    for (int i = 0; i < 10; i++) step(0, 0, enc_i(9, 0, 0, 1, 'h13));
    check("hold_pc", {24'b0, pc}, 32'd0);
    check("hold_x1", dut.regs[1], 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 32'h0);
      check("nop_pc", {24'b0, pc}, 32'(i));
    end

    // ALU
    do_reset();
    step(0, 1, enc_i(5, 0, 0, 1, 'h13));
    step(0, 1, enc_i(-3, 0, 0, 2, 'h13));
    step(0, 1, enc_r(0, 2, 1, 0, 3));
    step(0, 1, enc_r('h20, 1, 2, 0, 4));
    step(0, 1, enc_r(0, 1, 2, 2, 5));
    step(0, 1, enc_r(0, 1, 2, 3, 6));
    step(0, 1, enc_i('h401, 2, 5, 7, 'h13));
    check("addi_x1", dut.regs[1], 32'd5);
    check("addi_x2", dut.regs[2], 32'hFFFF_FFFD);
    check("add_x3",  dut.regs[3], 32'd2);
    check("sub_x4",  dut.regs[4], 32'hFFFF_FFF8);
    check("slt_x5",  dut.regs[5], 32'd1);
    check("sltu_x6", dut.regs[6], 32'd0);
    check("srai_x7", dut.regs[7], 32'hFFFF_FFFE);

    // x0 / LUI / AUIPC
    do_reset();
    step(0, 1, enc_i(7, 0, 0, 0, 'h13));
    check("x0_zero", dut.regs[0], 32'd0);
    step(0, 1, enc_u('h12345, 8, 'h37));
    check("lui_x8", dut.regs[8], 32'h1234_5000);
    step(0, 1, 32'h0);
    step(0, 1, enc_u(1, 9, 'h17));
    check("auipc_x9", dut.regs[9], 32'h0000_100C);

    // Branches
    do_reset();
    step(0, 1, enc_i(1, 0, 0, 1, 'h13));
    step(0, 1, enc_b(8, 0, 1, 0));
    check("beq_nt_pc", {24'b0, pc}, 32'd2);
    step(0, 1, enc_b(8, 0, 1, 1));
    check("bne_t_pc", {24'b0, pc}, 32'd4);
    step(0, 1, enc_b(8, 1, 0, 7));
    check("bgeu_nt_pc", {24'b0, pc}, 32'd5);
    step(0, 1, enc_b(8, 0, 1, 4));
    check("blt_nt_pc", {24'b0, pc}, 32'd6);

    // Jumps
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 32'h0);
    step(0, 1, enc_j(12, 1));
    check("jal_x1", dut.regs[1], 32'd24);
    check("jal_pc", {24'b0, pc}, 32'd8);
    step(0, 1, enc_i(4, 1, 0, 2, 'h67));
    check("jalr_pc", {24'b0, pc}, 32'd7);
    check("jalr_x2", dut.regs[2], 32'd36);

    // Illegal / store / PC wrap
    step(0, 1, 32'h0020_A223);
    step(0, 1, 32'h0001_00FF);
    check("nop_x1", dut.regs[1], 32'd24);
    while (m_pc != 255) step(0, 1, 32'h0);
    check("pc_255", {24'b0, pc}, 32'd255);
    step(0, 1, 32'h0);
    check("pc_wrap", {24'b0, pc}, 32'd0);

    // Random streams with occasional reset and hold cycles
    do_reset();
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 4) != 0, rand_ins());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
